nibble_add_scheduler: RTL and testbench
=======================================

NIBBLE_ADD_SCHEDULER -- requirements
Module: nibble_add_scheduler

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have ports r0_valid and r1_valid, input, 1 bit each, requester N has an operation pending.
REQ-005 The block SHALL have ports r0_ready and r1_ready, output, 1 bit each, requester N operands accepted this cycle.
REQ-006 The block SHALL have ports r0_a, r0_b, r1_a and r1_b, input, W bits each, the operands.
REQ-007 The block SHALL have ports r0_cin and r1_cin, input, 1 bit each, the carry-in.
REQ-008 The block SHALL have port res_valid, output, 1 bit, result held and valid.
REQ-009 The block SHALL have port res_ready, input, 1 bit, consumer takes the result.
REQ-010 The block SHALL have port res_id, output, 1 bit, index of the requester that owns the result.
REQ-011 The block SHALL have port res_sum, output, W bits, the sum.
REQ-012 The block SHALL have port res_cout, output, 1 bit, the final carry-out.

Function
REQ-013 The block SHALL time-share one 4-bit ripple adder slice between two requesters and compute a+b+cin over NIBBLES cycles, least-significant nibble first.
REQ-014 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-015 In IDLE, if r0_valid or r1_valid is high, the block SHALL grant one requester, drive that requester's rN_ready high combinationally in the same cycle, capture a, b, cin and id, clear nibble index idx to 0, and go to CALC.
REQ-016 Requester arbitration SHALL be round-robin: on a tie, the requester not granted last wins; the last-grant pointer resets to 1, so r0 wins the first tie.
REQ-017 r0_ready and r1_ready SHALL be low in every state other than IDLE and SHALL never both be high.
REQ-018 Each CALC cycle SHALL add nibble idx of a and b with the carry register, store the result nibble into res_sum[4*idx+3:4*idx], update the carry register, and increment idx.
REQ-019 When idx = NIBBLES-1, the CALC cycle SHALL load res_cout and go to DONE.
REQ-020 If acceptance occurs in cycle 0, res_valid SHALL be high from cycle NIBBLES+1.
REQ-021 In DONE, res_valid SHALL be 1 and res_sum, res_cout and res_id SHALL be held stable until res_valid and res_ready are both high, after which the FSM goes to IDLE.
REQ-022 No new request SHALL be accepted in the DONE cycle in which the result is taken; minimum spacing between acceptances is NIBBLES+2 cycles.
REQ-023 res_ready SHALL be ignored outside DONE.
REQ-024 rN_valid deasserted while not granted SHALL be legal; requester operands are sampled only in the acceptance cycle.

Reset
REQ-025 On reset, the FSM SHALL go to IDLE and clear idx, the carry register, res_valid, res_sum, res_cout and res_id to 0, and set the last-grant pointer to 1.
REQ-026 Reset asserted during CALC or DONE SHALL abandon the operation with no result delivered.
REQ-027 r0_ready and r1_ready SHALL be low during any cycle in which reset is high.

Configuration
REQ-028 With NIBBLE_ADD_OVF_EN defined, the block SHALL add output res_ovf, 1 bit, giving two's-complement overflow = a[W-1] ^ b[W-1] ^ res_sum[W-1] ^ res_cout.
REQ-029 res_ovf SHALL be registered with res_cout, held in DONE, and reset to 0.
REQ-030 Without NIBBLE_ADD_OVF_EN, the res_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 State encodings (IDLE=0, CALC=1, DONE=2) and the slice width constant 4 SHALL be defined in a shared `define` header included by the block.
REQ-032 The adder slice SHALL be one instance of the existing fulladder4_structural sub-module, with its carry_in driven from the carry register, or from the captured cin when idx = 0.
REQ-033 No other sub-module SHALL be used.

Verification
REQ-034 Test: r0 presents a=16'h00FF, b=16'h0001, cin=0, with res_ready held high -> r0_ready high for 1 cycle; res_valid high in cycle 5; res_sum=16'h0100, res_cout=0, res_id=0.
REQ-035 Test: r1 presents a=16'hFFFF, b=16'h0000, cin=1 -> res_sum=16'h0000, res_cout=1, res_id=1.
REQ-036 Test: r0 and r1 valid continuously from reset with res_ready high -> grants alternate 0,1,0,1 and acceptances occur exactly 6 cycles apart.
REQ-037 Test: result pending with res_ready low for 10 cycles -> res_valid and res_sum stable, both readies low, and no second acceptance.
REQ-038 Test: reset asserted in the 2nd CALC cycle -> next cycle all outputs 0 and state IDLE; a following r0 request completes correctly.
REQ-039 Test (NIBBLE_ADD_OVF_EN): a=16'h7FFF, b=16'h0001 -> res_sum=16'h8000, res_ovf=1, res_cout=0.

Source files
------------

// File: rtl/nibble_add_scheduler_pkg.sv
// nibble_add_scheduler_pkg
// Types and constants shared by the nibble-serial adder scheduler.
//   state_t   : scheduler FSM states (encodings from the shared define header)
//   SLICE_W   : width of the single adder slice (one nibble)
//   idx_width : width of the nibble index register for a given NIBBLES
package nibble_add_scheduler_pkg;

`include "nibble_add_scheduler_defs.svh"

    typedef enum logic [1:0] {
        IDLE = `NAS_STATE_IDLE,
        CALC = `NAS_STATE_CALC,
        DONE = `NAS_STATE_DONE
    } state_t;

    localparam int SLICE_W = `NAS_SLICE_W;

    // A single-nibble operand still needs a 1-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/fulladder4_structural.sv
// fulladder4_structural
// 4-bit ripple-carry adder built from per-bit full-adder equations.
// Ports:
//   a, b      : 4-bit addends
//   carry_in  : carry into bit 0
//   sum       : 4-bit sum
//   carry_out : carry out of bit 3
module fulladder4_structural (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [4:0] carry;

    assign carry[0] = carry_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry_out = carry[4];

endmodule

// File: rtl/nibble_add_scheduler_defs.svh
// Shared constants for nibble_add_scheduler: FSM state encodings and the
// width of the time-shared adder slice.
`ifndef NIBBLE_ADD_SCHEDULER_DEFS_SVH
`define NIBBLE_ADD_SCHEDULER_DEFS_SVH

`define NAS_STATE_IDLE 2'd0
`define NAS_STATE_CALC 2'd1
`define NAS_STATE_DONE 2'd2
`define NAS_SLICE_W    4

`endif

// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler
// Time-shares one 4-bit ripple adder slice between two requesters and
// computes a + b + cin one nibble per cycle, least-significant nibble first.
//
// Parameters:
//   NIBBLES : number of 4-bit slices per operand (W = 4*NIBBLES)
// Ports:
//   clk                  : clock, all logic on the rising edge
//   reset                : synchronous, active-high
//   r0_valid / r1_valid  : requester has an operation pending
//   r0_ready / r1_ready  : requester operands accepted this cycle (IDLE only)
//   r0_a, r0_b, r1_a, r1_b : W-bit operands
//   r0_cin / r1_cin      : carry-in
//   res_valid            : result held and valid
//   res_ready            : consumer takes the result (only looked at in DONE)
//   res_id               : requester that owns the result
//   res_sum              : W-bit sum
//   res_cout             : final carry-out
//   res_ovf              : two's-complement overflow (only with NIBBLE_ADD_OVF_EN)
//
// Build option: define NIBBLE_ADD_OVF_EN to add the res_ovf output.
//
// Timing: acceptance in cycle 0 gives CALC in cycles 1..NIBBLES and
// res_valid from cycle NIBBLES+1. Acceptances are at least NIBBLES+2 apart.
`include "nibble_add_scheduler_defs.svh"

module nibble_add_scheduler
    import nibble_add_scheduler_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = SLICE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         r0_valid,
    input  logic         r1_valid,
    output logic         r0_ready,
    output logic         r1_ready,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    input  logic         r0_cin,
    input  logic         r1_cin,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [W-1:0] res_sum,
    output logic         res_cout
`ifdef NIBBLE_ADD_OVF_EN
    ,
    output logic         res_ovf
`endif
);

    localparam int                 IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NIBBLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;

    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic               cin_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       res_sum_reg;
    logic               res_cout_reg;
    logic               res_valid_reg;
    logic               res_id_reg;
    logic               last_grant_reg;
`ifdef NIBBLE_ADD_OVF_EN
    logic               res_ovf_reg;
`endif

    // ------------------------------------------------------------------
    // Control strobes from the FSM
    // ------------------------------------------------------------------
    logic               grant_any;
    logic               grant_id;
    logic               accept;
    logic               calc_last;
    logic               take;

    // ------------------------------------------------------------------
    // Adder slice
    // ------------------------------------------------------------------
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               slice_cin;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign slice_a   = a_reg[SLICE_W*idx_reg +: SLICE_W];
    assign slice_b   = b_reg[SLICE_W*idx_reg +: SLICE_W];
    // The first nibble takes the requester's carry-in directly so the carry
    // register never has to be preloaded at acceptance.
    assign slice_cin = (idx_reg == '0) ? cin_reg : carry_reg;

    fulladder4_structural u_slice (
        .a         (slice_a),
        .b         (slice_b),
        .carry_in  (slice_cin),
        .sum       (slice_sum),
        .carry_out (slice_cout)
    );

    // ------------------------------------------------------------------
    // Round-robin arbitration: on a tie the requester not granted last wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant_reg;
        end else if (r0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
        end else if (r1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        accept     = 1'b0;
        calc_last  = 1'b0;
        take       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Readies are gated by reset so a request seen in a reset
                // cycle is never acknowledged.
                if (grant_any && !reset) begin
                    accept     = 1'b1;
                    r0_ready   = ~grant_id;
                    r1_ready   = grant_id;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (idx_reg == IDX_LAST) begin
                    calc_last  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_valid_reg && res_ready) begin
                    take       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg        <= '0;
            carry_reg      <= 1'b0;
            cin_reg        <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            res_sum_reg    <= '0;
            res_cout_reg   <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_id_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
`ifdef NIBBLE_ADD_OVF_EN
            res_ovf_reg    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_reg          <= grant_id ? r1_a   : r0_a;
                b_reg          <= grant_id ? r1_b   : r0_b;
                cin_reg        <= grant_id ? r1_cin : r0_cin;
                res_id_reg     <= grant_id;
                last_grant_reg <= grant_id;
                idx_reg        <= '0;
            end

            if (state_reg == CALC) begin
                res_sum_reg[SLICE_W*idx_reg +: SLICE_W] <= slice_sum;
                carry_reg <= slice_cout;
                if (calc_last) begin
                    idx_reg       <= '0;
                    res_cout_reg  <= slice_cout;
                    res_valid_reg <= 1'b1;
`ifdef NIBBLE_ADD_OVF_EN
                    // slice_sum[MSB] is the top bit of the final sum here.
                    res_ovf_reg   <= a_reg[W-1] ^ b_reg[W-1]
                                   ^ slice_sum[SLICE_W-1] ^ slice_cout;
`endif
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end

            if (take) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign res_sum   = res_sum_reg;
    assign res_cout  = res_cout_reg;
`ifdef NIBBLE_ADD_OVF_EN
    assign res_ovf   = res_ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// tb_nibble_add_scheduler
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level reference model (arbitration rule, fixed
// latency, a+b+cin arithmetic). Define NIBBLE_ADD_OVF_EN to cover res_ovf.
module tb_nibble_add_scheduler;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset;
    logic         r0_valid, r1_valid;
    logic         r0_ready, r1_ready;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic         r0_cin, r1_cin;
    logic         res_valid, res_ready, res_id, res_cout;
    logic [W-1:0] res_sum;
`ifdef NIBBLE_ADD_OVF_EN
    logic         res_ovf;
`endif

    nibble_add_scheduler #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_valid  (r0_valid),
        .r1_valid  (r1_valid),
        .r0_ready  (r0_ready),
        .r1_ready  (r1_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .r0_cin    (r0_cin),
        .r1_cin    (r1_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
`ifdef NIBBLE_ADD_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .res_cout  (res_cout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    bit           m_busy  = 1'b0;
    bit           m_clear = 1'b0;
    int           m_cnt   = 0;
    int           m_last  = 1;
    logic [W-1:0] m_sum;
    logic         m_cout, m_id, m_ovf;
    int           acc_cyc[$];
    int           acc_id[$];

    // DUT observations of the last completed cycle
    logic         s_valid, s_cout, s_id;
    logic [W-1:0] s_sum;
`ifdef NIBBLE_ADD_OVF_EN
    logic         s_ovf;
`endif
    int           obs_acc   = 0;
    int           obs_r0_rd = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already applied: checks
    // the current cycle against the model, advances the model, then moves
    // on to the next falling edge.
    task automatic cycle();
        bit           e0, e1, ev;
        logic [W:0]   full;
        logic [W-1:0] a, b;
        logic         c;
        #1;
        e0 = !reset && !m_busy && r0_valid && (!r1_valid || m_last == 1);
        e1 = !reset && !m_busy && r1_valid && (!r0_valid || m_last == 0);
        ev = m_busy && (m_cnt >= NIBBLES + 1);
        chk("r0_ready", r0_ready, e0);
        chk("r1_ready", r1_ready, e1);
        chk("res_valid", res_valid, ev);
        if (ev) begin
            chk("res_sum", res_sum, m_sum);
            chk("res_cout", res_cout, m_cout);
            chk("res_id", res_id, m_id);
`ifdef NIBBLE_ADD_OVF_EN
            chk("res_ovf", res_ovf, m_ovf);
`endif
        end
        if (!m_busy && m_clear) begin
            chk("clr_sum", res_sum, 0);
            chk("clr_cout", res_cout, 0);
            chk("clr_id", res_id, 0);
`ifdef NIBBLE_ADD_OVF_EN
            chk("clr_ovf", res_ovf, 0);
`endif
        end
        s_valid = res_valid;
        s_sum   = res_sum;
        s_cout  = res_cout;
        s_id    = res_id;
`ifdef NIBBLE_ADD_OVF_EN
        s_ovf   = res_ovf;
`endif
        if (r0_ready || r1_ready) obs_acc++;
        if (r0_ready) obs_r0_rd++;

        if (reset) begin
            m_busy  = 1'b0;
            m_last  = 1;
            m_clear = 1'b1;
        end else if (e0 || e1) begin
            a      = e1 ? r1_a : r0_a;
            b      = e1 ? r1_b : r0_b;
            c      = e1 ? r1_cin : r0_cin;
            full   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            m_sum  = full[W-1:0];
            m_cout = full[W];
            m_ovf  = (a[W-1] == b[W-1]) && (m_sum[W-1] != a[W-1]);
            m_id   = e1;
            m_last = e1 ? 1 : 0;
            m_busy  = 1'b1;
            m_cnt   = 1;
            m_clear = 1'b0;
            acc_cyc.push_back(cyc);
            acc_id.push_back(e1 ? 1 : 0);
        end else if (m_busy) begin
            if (ev && res_ready) m_busy = 1'b0;
            else m_cnt++;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        r0_valid = 0; r1_valid = 0;
        r0_a = '0; r0_b = '0; r0_cin = 0;
        r1_a = '0; r1_b = '0; r1_cin = 0;
    endtask

    initial begin
        int n;
        int base_acc;
        int base_r0;

        idle_inputs();
        res_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_clear = 1'b1;
        cycle();
        reset = 1'b0;

        // Reset state
        cycle();
        chk("rst_valid", s_valid, 0);
        chk("rst_sum", s_sum, 0);

        // r0: 00FF + 0001 + 0, result in cycle 5
        base_r0 = obs_r0_rd;
        r0_valid = 1; r0_a = 16'h00FF; r0_b = 16'h0001; r0_cin = 0;
        cycle();
        idle_inputs();
        n = 0;
        do begin cycle(); n++; end while (!s_valid && n < 20);
        chk("t1_latency", n, 5);
        chk("t1_sum", s_sum, 16'h0100);
        chk("t1_cout", s_cout, 0);
        chk("t1_id", s_id, 0);
        chk("t1_r0_ready_cycles", obs_r0_rd - base_r0, 1);
        cycle();

        // r1: FFFF + 0000 + 1
        r1_valid = 1; r1_a = 16'hFFFF; r1_b = 16'h0000; r1_cin = 1;
        cycle();
        idle_inputs();
        n = 0;
        do begin cycle(); n++; end while (!s_valid && n < 20);
        chk("t2_sum", s_sum, 16'h0000);
        chk("t2_cout", s_cout, 1);
        chk("t2_id", s_id, 1);
        cycle();

        // Both requesting continuously from reset: alternate and 6 apart
        reset = 1; r0_valid = 1; r1_valid = 1;
        r0_a = 16'h1111; r0_b = 16'h2222; r1_a = 16'h8000; r1_b = 16'h8000; r1_cin = 1;
        cycle();
        reset = 0;
        acc_cyc.delete(); acc_id.delete();
        n = 0;
        while (acc_id.size() < 4 && n < 60) begin cycle(); n++; end
        chk("t3_accepts", acc_id.size(), 4);
        for (int i = 0; i < acc_id.size(); i++) begin
            chk("t3_grant_id", acc_id[i], i % 2);
            if (i > 0) chk("t3_spacing", acc_cyc[i] - acc_cyc[i-1], NIBBLES + 2);
        end
        idle_inputs();
        n = 0;
        while (m_busy && n < 20) begin cycle(); n++; end
        chk("t3_drain", m_busy, 0);

        // Result stalled for 10 cycles with both requesters waiting
        res_ready = 0;
        r0_valid = 1; r0_a = 16'h1234; r0_b = 16'h4321; r0_cin = 1;
        cycle();
        r1_valid = 1;
        n = 0;
        do begin cycle(); n++; end while (!s_valid && n < 20);
        chk("t4_valid", s_valid, 1);
        base_acc = obs_acc;
        repeat (10) cycle();
        chk("t4_sum", s_sum, 16'h5556);
        chk("t4_valid_held", s_valid, 1);
        chk("t4_no_accept", obs_acc - base_acc, 0);
        idle_inputs();
        res_ready = 1;
        cycle();

        // Reset in the 2nd CALC cycle, then a clean r0 request
        r0_valid = 1; r0_a = 16'hABCD; r0_b = 16'h1357; r0_cin = 1;
        cycle();
        idle_inputs();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        r0_valid = 1; r0_a = 16'h0F0F; r0_b = 16'hF0F1; r0_cin = 0;
        base_acc = obs_acc;
        cycle();
        chk("t5_clr_valid", s_valid, 0);
        chk("t5_clr_sum", s_sum, 0);
        chk("t5_clr_id", s_id, 0);
        chk("t5_idle_accept", obs_acc - base_acc, 1);
        idle_inputs();
        n = 0;
        do begin cycle(); n++; end while (!s_valid && n < 20);
        chk("t5_sum", s_sum, 16'h0000);
        chk("t5_cout", s_cout, 1);
        cycle();

`ifdef NIBBLE_ADD_OVF_EN
        // Signed overflow: 7FFF + 0001
        r0_valid = 1; r0_a = 16'h7FFF; r0_b = 16'h0001; r0_cin = 0;
        cycle();
        idle_inputs();
        n = 0;
        do begin cycle(); n++; end while (!s_valid && n < 20);
        chk("t6_sum", s_sum, 16'h8000);
        chk("t6_ovf", s_ovf, 1);
        chk("t6_cout", s_cout, 0);
        cycle();
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r0_valid  = ($urandom_range(0, 99) < 60);
            r1_valid  = ($urandom_range(0, 99) < 60);
            r0_a      = W'($urandom);
            r0_b      = W'($urandom);
            r1_a      = W'($urandom);
            r1_b      = W'($urandom);
            r0_cin    = 1'($urandom_range(0, 1));
            r1_cin    = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 99) < 50);
            reset     = ($urandom_range(0, 99) < 2);
            cycle();
        end
        reset = 0;
        idle_inputs();
        res_ready = 1;
        repeat (NIBBLES + 3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
